// File: rtl/riscv_pkg.sv
// Shared decode/issue definitions for the integer pipeline.
// Holds opcode constants, scoreboard defaults and the issue FSM states.
package riscv_pkg;

    localparam int NREG_DEF = 32;
    localparam int CNTW_DEF = 2;

    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [4:0] REG_X0     = 5'd0;

    typedef enum logic [1:0] {
        RUN,
        SERIAL,
        RECOVER
    } sb_state_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: saturating up/down count of writes in flight
// to a single architectural register.
module sb_entry #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            inc,
    input  logic            dec,
    input  logic            clr,
    output logic [CNTW-1:0] cnt,
    output logic            busy,
    output logic            full
);

    assign busy = |cnt;
    assign full = &cnt;

    // Simultaneous inc and dec cancel; dec on an idle slot is dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && busy) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage register scoreboard and issue controller.
// Tracks in-flight rd writes, serialises SYSTEM ops and recovers from flush.
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DE_V,
    input  logic [4:0]  DE_RS1,
    input  logic [4:0]  DE_RS2,
    input  logic [4:0]  DE_RD,
    input  logic        DE_USE_RS1,
    input  logic        DE_USE_RS2,
    input  logic        DE_WR_RD,
    input  logic        DE_SERIAL,
    input  logic        WB_RET,
    input  logic [4:0]  WB_DR,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        ISSUE,
    output logic        SB_EMPTY,
    output logic [31:0] STALL_CNT
);

    sb_state_t state;
    sb_state_t state_nx;

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] full;

    logic wr_en;
    logic rt_en;
    logic clr;
    logic any_busy;
    logic rs1_haz;
    logic rs2_haz;
    logic rd_full;
    logic ser_block;
    logic stall;

    // Flush kills both the issuing and the retiring side of the update.
    assign wr_en = ISSUE && DE_WR_RD && !FLUSH;
    assign rt_en = WB_RET && !FLUSH;
    assign clr   = RESET || FLUSH;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;
    assign full[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_ent
        sb_entry #(
            .CNTW (CNTW)
        ) u_ent (
            .clk  (CLK),
            .inc  (wr_en && (DE_RD == 5'(i))),
            .dec  (rt_en && (WB_DR == 5'(i))),
            .clr  (clr),
            .cnt  (cnt[i]),
            .busy (busy[i]),
            .full (full[i])
        );
    end

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            any_busy = any_busy || (|cnt[i]);
        end
    end

    assign SB_EMPTY = !any_busy;

    assign rs1_haz = DE_USE_RS1 && (DE_RS1 != REG_X0) && busy[DE_RS1];
    assign rs2_haz = DE_USE_RS2 && (DE_RS2 != REG_X0) && busy[DE_RS2];
    assign rd_full = DE_WR_RD && (DE_RD != REG_X0) && full[DE_RD];
    assign ser_block = DE_V && DE_SERIAL && !SB_EMPTY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        unique case (state)
            RUN: begin
                stall = rs1_haz || rs2_haz || rd_full || ser_block;
                if (ser_block) begin
                    state_nx = SERIAL;
                end
            end
            SERIAL: begin
                stall = !SB_EMPTY;
                if (!DE_V || SB_EMPTY) begin
                    state_nx = RUN;
                end
            end
            RECOVER: begin
                stall    = 1'b1;
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
        if (FLUSH) begin
            state_nx = RECOVER;
        end
    end

    assign STALL = stall;
    assign ISSUE = DE_V && !stall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_CNT <= '0;
        end else if (stall && DE_V && !(&STALL_CNT)) begin
            STALL_CNT <= STALL_CNT + 32'd1;
        end
    end

endmodule
